mem_arbiter_rr2: RTL and testbench
==================================

MEM_ARBITER_RR2 -- requirements
Module: mem_arbiter_rr2

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: slave wait cycles before forced abort (range 1..65535).
REQ-002 Parameter ERR_DATA, default 32'hDEADBEEF, meaning: read data returned on abort.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mN_valid  input  1  master N (N=0,1) request, picorv32 native bus.
REQ-006 mN_instr  input  1  master N instruction-fetch flag.
REQ-007 mN_addr  input  32  master N byte address.
REQ-008 mN_wdata  input  32  master N write data.
REQ-009 mN_wstrb  input  4  master N byte strobes; 0 means read.
REQ-010 mN_ready  output  1  master N transfer complete.
REQ-011 mN_rdata  output  32  master N read data.
REQ-012 s_valid, s_instr, s_addr, s_wdata, s_wstrb  output  1/1/32/32/4  forwarded request to the shared memory/cache slave.
REQ-013 s_ready  input  1  slave completion; s_rdata  input  32  slave read data.
REQ-014 grant  output  2  one-hot current owner (bit N = master N), 2'b00 when idle.
REQ-015 timeout_err  output  1  one-cycle pulse on forced abort.

Function
REQ-016 FSM states IDLE, OWN0, OWN1; state and grant registered, all mux paths combinational from state.
REQ-017 IDLE: exactly one mN_valid high -> next state OWNN; both high -> owner is master not equal to last_owner register; none -> stay IDLE.
REQ-018 last_owner updates to N on every exit from OWNN; reset value 1, so master 0 wins the first tie.
REQ-019 In OWNN: s_valid = mN_valid, s_instr/s_addr/s_wdata/s_wstrb = master N fields; other master sees mN_ready=0.
REQ-020 In IDLE: s_valid=0, s_addr/s_wdata=0, s_wstrb=0, s_instr=0.
REQ-021 In OWNN: mN_ready = s_ready, mN_rdata = s_rdata, same cycle; non-owner rdata = 0.
REQ-022 s_ready high in OWNN -> IDLE at next edge; minimum latency request-to-s_valid = 1 cycle; one IDLE bubble between back-to-back transfers.
REQ-023 Owner drops mN_valid before s_ready (protocol violation) -> IDLE at next edge, no ready, no error.
REQ-024 16-bit wait counter clears on entry to OWNN, increments each OWNN cycle with s_ready=0, saturates.
REQ-025 Counter == TIMEOUT and s_ready=0 -> that cycle: s_valid=0, mN_ready=1, mN_rdata=ERR_DATA, timeout_err=1; next state IDLE.
REQ-026 s_ready and timeout in same cycle -> s_ready wins, normal completion, no timeout_err.
REQ-027 s_ready while IDLE is ignored; no ready forwarded to any master.
REQ-028 Requests held by non-owner are never dropped; served after current owner exits (starvation-free, max one transfer wait).

Reset
REQ-029 reset high -> immediately state IDLE, grant=00, last_owner=1, counter=0, all outputs 0, independent of clk.
REQ-030 Reset mid-transfer aborts silently: no ready, no timeout_err; first arbitration after reset release follows REQ-017/018.

Verification
REQ-031 m0_valid only, addr 0x100, wstrb 0, slave ready after 3 cycles with rdata 0x12345678 -> grant=01 one cycle after request, m0_ready=1 with m0_rdata 0x12345678, m1_ready stays 0.
REQ-032 Both valid from reset release, slave 1-cycle ready -> grants 01,00,10,00,01 ordered; each master alternately completes.
REQ-033 m1 write addr 0x200, wdata 0xA5A5A5A5, wstrb 1111 -> s_addr/s_wdata/s_wstrb match exactly while grant=10.
REQ-034 TIMEOUT=4, slave never ready -> after 4 wait cycles m0_ready=1, m0_rdata=0xDEADBEEF, timeout_err one-cycle pulse, then IDLE.
REQ-035 TIMEOUT=4, s_ready asserted on the 4th wait cycle -> normal completion with slave data, timeout_err=0.
REQ-036 reset pulsed while OWN1 waiting -> grant=00, s_valid=0 asynchronously; after release with both valid, master 0 granted first.

Source files
------------

// File: rtl/mem_arbiter_rr2_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_rr2_if
//  Description : Bus bundle for the two-master picorv32-native-bus arbiter.
//                Carries both master request/response channels and the
//                forwarded request/response channel of the shared slave.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_rr2_if;

    // Master 0 channel
    logic        m0_valid;
    logic        m0_instr;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_ready;
    logic [31:0] m0_rdata;

    // Master 1 channel
    logic        m1_valid;
    logic        m1_instr;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_ready;
    logic [31:0] m1_rdata;

    // Shared slave channel
    logic        s_valid;
    logic        s_instr;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;

    // Arbiter view: accepts master requests, drives the slave request.
    modport slave (
        input  m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
        output m1_ready, m1_rdata,
        output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );

    // Environment view: masters plus the shared memory slave.
    modport master (
        output m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb,
        input  m1_ready, m1_rdata,
        input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_rr2
//  Description : Two-master round-robin arbiter for a shared picorv32 native
//                bus slave. Registered owner state, combinational request and
//                response muxing, and a wait counter that force-completes a
//                stalled transfer with ERR_DATA and a timeout_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr2 #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  wire logic         clk,
    input  wire logic         reset,
    mem_arbiter_rr2_if.slave  bus,
    output logic [1:0]        grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

    state_t      state_q;
    logic [1:0]  grant_q;
    logic        last_owner_q;   // master that most recently left ownership
    logic [15:0] wait_cnt_q;
    logic [15:0] wait_cnt_d;

    logic        own0;
    logic        own1;
    logic        own_valid;      // current owner still holds its request
    logic        xfer_done;      // slave completed the owner's transfer
    logic        xfer_abort;     // wait budget exhausted without completion

    // Ownership decode, completion/abort qualification, saturating count.
    always_comb begin
        own0       = (state_q == ST_OWN0);
        own1       = (state_q == ST_OWN1);
        own_valid  = (own0 & bus.m0_valid) | (own1 & bus.m1_valid);
        // A slave ready in the timeout cycle still counts as a normal finish.
        xfer_done  = own_valid & bus.s_ready;
        xfer_abort = own_valid & ~bus.s_ready & (wait_cnt_q == C_TIMEOUT);
        wait_cnt_d = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : (wait_cnt_q + 16'd1);
    end

    // Owner FSM with registered grant, fairness pointer and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
            wait_cnt_q   <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Counter is held at zero while idle so every entry into
                    // ownership starts a fresh wait budget.
                    wait_cnt_q <= 16'd0;
                    // On a tie the master that did not own last goes first.
                    if (bus.m0_valid && (!bus.m1_valid || last_owner_q)) begin
                        state_q <= ST_OWN0;
                        grant_q <= 2'b01;
                    end else if (bus.m1_valid) begin
                        state_q <= ST_OWN1;
                        grant_q <= 2'b10;
                    end
                end
                ST_OWN0, ST_OWN1: begin
                    // Any exit (completion, abort, or request withdrawn)
                    // returns to idle, leaving one bubble between transfers.
                    if (!own_valid || xfer_done || xfer_abort) begin
                        state_q      <= ST_IDLE;
                        grant_q      <= 2'b00;
                        last_owner_q <= own1;
                        wait_cnt_q   <= 16'd0;
                    end else begin
                        wait_cnt_q   <= wait_cnt_d;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    grant_q    <= 2'b00;
                    wait_cnt_q <= 16'd0;
                end
            endcase
        end
    end

    // Request forwarding and response steering, purely from owner state.
    always_comb begin
        bus.s_valid  = 1'b0;
        bus.s_instr  = 1'b0;
        bus.s_addr   = 32'd0;
        bus.s_wdata  = 32'd0;
        bus.s_wstrb  = 4'd0;
        bus.m0_ready = 1'b0;
        bus.m0_rdata = 32'd0;
        bus.m1_ready = 1'b0;
        bus.m1_rdata = 32'd0;

        if (own0) begin
            bus.s_valid  = bus.m0_valid & ~xfer_abort;
            bus.s_instr  = bus.m0_instr;
            bus.s_addr   = bus.m0_addr;
            bus.s_wdata  = bus.m0_wdata;
            bus.s_wstrb  = bus.m0_wstrb;
            bus.m0_ready = xfer_done | xfer_abort;
            bus.m0_rdata = xfer_abort ? ERR_DATA : bus.s_rdata;
        end

        if (own1) begin
            bus.s_valid  = bus.m1_valid & ~xfer_abort;
            bus.s_instr  = bus.m1_instr;
            bus.s_addr   = bus.m1_addr;
            bus.s_wdata  = bus.m1_wdata;
            bus.s_wstrb  = bus.m1_wstrb;
            bus.m1_ready = xfer_done | xfer_abort;
            bus.m1_rdata = xfer_abort ? ERR_DATA : bus.s_rdata;
        end
    end

    // Status outputs: registered grant, same-cycle abort pulse.
    always_comb begin
        grant       = grant_q;
        timeout_err = xfer_abort;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter_rr2
//  Description : Directed self-checking bench for mem_arbiter_rr2 (TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr2;

    logic       clk;
    logic       reset;
    logic [1:0] grant;
    logic       timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter_rr2_if bus ();

    mem_arbiter_rr2 #(
        .TIMEOUT  (4),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.m0_valid = 1'b0; bus.m0_instr = 1'b0; bus.m0_addr = 32'd0;
        bus.m0_wdata = 32'd0; bus.m0_wstrb = 4'd0;
        bus.m1_valid = 1'b0; bus.m1_instr = 1'b0; bus.m1_addr = 32'd0;
        bus.m1_wdata = 32'd0; bus.m1_wstrb = 4'd0;
        bus.s_ready  = 1'b0; bus.s_rdata = 32'd0;
        step();
        step();

        // Reset state
        chk2 ("rst_grant",   grant, 2'b00);
        chk1 ("rst_svalid",  bus.s_valid, 1'b0);
        chk1 ("rst_m0ready", bus.m0_ready, 1'b0);
        chk1 ("rst_m1ready", bus.m1_ready, 1'b0);
        chk1 ("rst_tmo",     timeout_err, 1'b0);

        // ---- m0 read, slave ready on third owned cycle ----
        reset = 1'b0;
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h100; bus.m0_wstrb = 4'd0;
        bus.m0_instr = 1'b1;
        #1;
        chk2 ("rd_idle_grant", grant, 2'b00);
        chk1 ("rd_idle_svalid", bus.s_valid, 1'b0);
        step();
        chk2 ("rd_grant",  grant, 2'b01);
        chk1 ("rd_svalid", bus.s_valid, 1'b1);
        chk32("rd_saddr",  bus.s_addr, 32'h100);
        chk1 ("rd_sinstr", bus.s_instr, 1'b1);
        chk1 ("rd_c1_m0ready", bus.m0_ready, 1'b0);
        step();
        chk1 ("rd_c2_m0ready", bus.m0_ready, 1'b0);
        step();
        bus.s_ready = 1'b1; bus.s_rdata = 32'h12345678;
        #1;
        chk1 ("rd_m0ready", bus.m0_ready, 1'b1);
        chk32("rd_m0rdata", bus.m0_rdata, 32'h12345678);
        chk1 ("rd_m1ready", bus.m1_ready, 1'b0);
        chk32("rd_m1rdata", bus.m1_rdata, 32'h0);
        chk1 ("rd_tmo",     timeout_err, 1'b0);
        step();
        bus.m0_valid = 1'b0; bus.m0_instr = 1'b0;
        // slave ready while idle must not leak to any master
        bus.s_ready = 1'b1; bus.s_rdata = 32'h0BADF00D;
        #1;
        chk2 ("rd_done_grant", grant, 2'b00);
        chk32("idle_saddr",    bus.s_addr, 32'h0);
        chk1 ("idle_sinstr",   bus.s_instr, 1'b0);
        chk1 ("idle_m0ready",  bus.m0_ready, 1'b0);
        chk1 ("idle_m1ready",  bus.m1_ready, 1'b0);
        bus.s_ready = 1'b0;

        // ---- m1 write, with m0 queued behind it ----
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h200; bus.m1_wdata = 32'hA5A5A5A5;
        bus.m1_wstrb = 4'b1111;
        step();
        bus.m0_valid = 1'b1; bus.m0_addr = 32'h300; bus.m0_wstrb = 4'd0;
        #1;
        chk2 ("wr_grant",  grant, 2'b10);
        chk1 ("wr_svalid", bus.s_valid, 1'b1);
        chk32("wr_saddr",  bus.s_addr, 32'h200);
        chk32("wr_swdata", bus.s_wdata, 32'hA5A5A5A5);
        chk32("wr_swstrb", {28'd0, bus.s_wstrb}, 32'hF);
        chk1 ("wr_m0ready_nonowner", bus.m0_ready, 1'b0);
        bus.s_ready = 1'b1; bus.s_rdata = 32'h55;
        #1;
        chk1 ("wr_m1ready", bus.m1_ready, 1'b1);
        chk1 ("wr_m0ready", bus.m0_ready, 1'b0);
        chk32("wr_m0rdata", bus.m0_rdata, 32'h0);
        step();
        bus.m1_valid = 1'b0; bus.s_ready = 1'b0; bus.s_rdata = 32'h0;
        #1;
        chk2 ("wr_bubble_grant", grant, 2'b00);

        // ---- queued m0 served, slave never ready -> forced abort ----
        step();
        chk2 ("tmo_grant", grant, 2'b01);
        chk32("tmo_saddr", bus.s_addr, 32'h300);
        step();
        step();
        step();
        chk1 ("tmo_w4_m0ready", bus.m0_ready, 1'b0);
        chk1 ("tmo_w4_tmo",     timeout_err, 1'b0);
        step();
        chk1 ("tmo_svalid",  bus.s_valid, 1'b0);
        chk1 ("tmo_m0ready", bus.m0_ready, 1'b1);
        chk32("tmo_m0rdata", bus.m0_rdata, 32'hDEADBEEF);
        chk1 ("tmo_pulse",   timeout_err, 1'b1);
        step();
        bus.m0_valid = 1'b0;
        #1;
        chk1 ("tmo_pulse_end", timeout_err, 1'b0);
        chk2 ("tmo_idle",      grant, 2'b00);

        // ---- slave ready on fourth wait cycle -> normal finish ----
        bus.m0_valid = 1'b1;
        step();
        step();
        step();
        step();
        bus.s_ready = 1'b1; bus.s_rdata = 32'hCAFEF00D;
        #1;
        chk1 ("w4_m0ready", bus.m0_ready, 1'b1);
        chk32("w4_m0rdata", bus.m0_rdata, 32'hCAFEF00D);
        chk1 ("w4_tmo",     timeout_err, 1'b0);
        step();
        bus.s_ready = 1'b0;

        // ---- slave ready exactly at the timeout cycle -> slave wins ----
        step();
        chk2 ("race_grant", grant, 2'b01);
        step();
        step();
        step();
        step();
        bus.s_ready = 1'b1; bus.s_rdata = 32'h600DD00D;
        #1;
        chk1 ("race_svalid",  bus.s_valid, 1'b1);
        chk1 ("race_m0ready", bus.m0_ready, 1'b1);
        chk32("race_m0rdata", bus.m0_rdata, 32'h600DD00D);
        chk1 ("race_tmo",     timeout_err, 1'b0);
        step();
        bus.s_ready = 1'b0; bus.m0_valid = 1'b0;

        // ---- owner withdraws request: silent return to idle ----
        bus.m1_valid = 1'b1; bus.m1_addr = 32'h400; bus.m1_wstrb = 4'd0;
        step();
        step();
        chk2 ("wd_grant", grant, 2'b10);
        bus.m1_valid = 1'b0;
        #1;
        chk1 ("wd_m1ready", bus.m1_ready, 1'b0);
        chk1 ("wd_tmo",     timeout_err, 1'b0);
        chk1 ("wd_svalid",  bus.s_valid, 1'b0);
        step();
        chk2 ("wd_idle", grant, 2'b00);

        // ---- reset while m1 is waiting, then alternating service ----
        bus.m1_valid = 1'b1;
        step();
        chk2 ("rm_grant", grant, 2'b10);
        step();
        reset = 1'b1;
        bus.m0_valid = 1'b1;
        #1;
        chk2 ("rm_async_grant",  grant, 2'b00);
        chk1 ("rm_async_svalid", bus.s_valid, 1'b0);
        chk1 ("rm_async_m1rdy",  bus.m1_ready, 1'b0);
        chk1 ("rm_async_tmo",    timeout_err, 1'b0);
        step();
        reset = 1'b0;
        bus.s_ready = 1'b1; bus.s_rdata = 32'h11111111;
        #1;
        chk2 ("rr_rel_grant", grant, 2'b00);
        step();
        chk2 ("rr_g1", grant, 2'b01);
        chk1 ("rr_g1_m0ready", bus.m0_ready, 1'b1);
        chk32("rr_g1_m0rdata", bus.m0_rdata, 32'h11111111);
        chk1 ("rr_g1_m1ready", bus.m1_ready, 1'b0);
        step();
        chk2 ("rr_g2", grant, 2'b00);
        step();
        chk2 ("rr_g3", grant, 2'b10);
        chk1 ("rr_g3_m1ready", bus.m1_ready, 1'b1);
        chk1 ("rr_g3_m0ready", bus.m0_ready, 1'b0);
        step();
        chk2 ("rr_g4", grant, 2'b00);
        step();
        chk2 ("rr_g5", grant, 2'b01);
        chk1 ("rr_g5_m0ready", bus.m0_ready, 1'b1);

        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0; bus.s_ready = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
